seqdiv32: RTL
=============

# seqdiv32

Multi-cycle 32-bit integer divider for the execute stage, alongside `alu32`. `alu32` turns operands into a result in one combinational pass. This block is the sequential counterpart for the operation the ALU cannot do: it accepts a dividend/divisor pair on a start handshake, runs a fixed-latency restoring shift-subtract loop, and returns quotient, remainder and status flags. Signed and unsigned division are both supported, with a fixed, data-independent latency.

## Interface
- No parameters; width fixed at 32.
- `clock`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; accepted only on an edge where `ready`=1.
- `is_signed`  in  1  1 = two's-complement divide, 0 = unsigned; sampled with `start`.
- `dividend`  in  32  numerator; sampled with `start`.
- `divisor`  in  32  denominator; sampled with `start`.
- `ready`  out  1  high in IDLE only.
- `done`  out  1  one-cycle pulse; results valid.
- `quotient`  out  32  result, held until next accepted start.
- `remainder`  out  32  result, held until next accepted start.
- `div_by_zero`  out  1  divisor was 0; held with results.

## Operation
- States: IDLE, PREP, ITER, FIX, DONE.
- **IDLE**
  - `ready`=1.
  - On `start`: latch operands and `is_signed`; go to PREP.
- **PREP** (1 cycle)
  - Record `neg_q` = signed & (sign(dividend) ^ sign(divisor)).
  - Record `neg_r` = signed & sign(dividend).
  - Replace operands with their magnitudes when signed and negative.
  - Clear the 33-bit partial remainder `R` and the iteration counter; go to ITER.
- **ITER** (exactly 32 cycles; counter runs 0..31)
  - Shift {R, Q} left 1.
  - `T` = R − {1'b0, D}, computed with a 33-bit subtractor.
  - If T ≥ 0: R ← T and Q[0] ← 1. Otherwise Q[0] ← 0.
  - Counter == 31 → FIX.
- **FIX** (1 cycle)
  - `quotient` = neg_q ? −Q : Q.
  - `remainder` = neg_r ? −R[31:0] : R[31:0].
  - If the latched divisor == 0: `quotient` = 32'hFFFFFFFF, `remainder` = original dividend, `div_by_zero`=1. Same latency as a normal divide.
  - Go to DONE.
- **DONE** (1 cycle): `done`=1; go to IDLE.
- Signed overflow (0x80000000 / 0xFFFFFFFF) is not special-cased. The algorithm yields quotient 0x80000000, remainder 0.
- `start` while not IDLE is ignored; no queueing.
- Operand inputs are don't-care except on the accepting edge.

## Timing
- Reset (asynchronous, any state, including mid-ITER):
  - state=IDLE, `ready`=1, `done`=0.
  - `quotient`, `remainder`, `div_by_zero` = 0.
  - The in-flight operation is discarded.
- The first edge with `reset_n` high may already accept `start`.
- Edge E0 accepts `start`; `ready` is low from E0.
- Sequence:
  - PREP occupies E0→E1.
  - ITER occupies E1→E33.
  - FIX occupies E33→E34.
  - `done` is high for E34→E35.
  - `ready` returns at E35.
- A new `start` may be accepted on E35. Throughput is one divide per 35 cycles.
- `quotient`, `remainder` and `div_by_zero` update only at E34. They are stable from `done` until the next accepted start plus 34 edges.

## Structure
- Shared package holds:
  - state encoding, 3-bit localparams for the five states;
  - `DIV_ITERS` = 32;
  - the divide-by-zero quotient constant 32'hFFFFFFFF.
- Natural sub-module: `div_step`, combinational. Takes R, Q, D; returns next R and next Q for one iteration.
- FSM, counter and sign fixup stay in the top module.
- `alu32` is not instantiated: it exposes no carry-out, and the compare needs 33 bits.

## Test plan
- Unsigned 100 / 7 → `done` exactly 34 edges after the accepting edge; quotient 14, remainder 2, `div_by_zero` 0.
- Signed −7 / 2 (0xFFFFFFF9, 2) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7 / −2 → quotient 0xFFFFFFFD, remainder 1.
- 0x80000000 / 0xFFFFFFFF:
  - signed → quotient 0x80000000, remainder 0;
  - unsigned → quotient 0, remainder 0x80000000.
- 5 / 0 (both modes) → quotient 0xFFFFFFFF, remainder 5, `div_by_zero` 1, same latency.
- Pulse `start` with new operands at E10 of a busy divide → ignored; first result unchanged; second start accepted on E35.
- Assert `reset_n`=0 mid-ITER → outputs immediately 0 and `ready`=1. After release, 9 / 3 → quotient 3, remainder 0.

Source files
------------

// File: rtl/seqdiv32_pkg.sv
// Shared definitions for the sequential 32-bit divider: state encoding,
// iteration count, divide-by-zero result constant and a magnitude helper.
package seqdiv32_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_ITERS = 32;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_PREP = 3'd1;
    localparam state_t ST_ITER = 3'd2;
    localparam state_t ST_FIX  = 3'd3;
    localparam state_t ST_DONE = 3'd4;

    // Counter value of the final shift-subtract step.
    localparam logic [4:0] LAST_ITER = 5'(DIV_ITERS - 1);

    // Quotient reported when the divisor is zero.
    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOTIENT = 32'hFFFF_FFFF;

    // Two's-complement magnitude; 0x80000000 maps to itself, which reads
    // correctly as the unsigned value 2^31.
    function automatic logic [DIV_WIDTH-1:0] magnitude32(input logic [DIV_WIDTH-1:0] value);
        return value[DIV_WIDTH-1] ? (~value + 32'd1) : value;
    endfunction

endpackage

// File: rtl/seqdiv32_div_step.sv
// One restoring shift-subtract step of the divider: shifts {R, Q} left by
// one, trial-subtracts the divisor and keeps the difference when it is
// non-negative, recording the outcome in the new quotient LSB.
module seqdiv32_div_step
    import seqdiv32_pkg::*;
(
    input  logic [DIV_WIDTH:0]   rem_in,
    input  logic [DIV_WIDTH-1:0] quot_in,
    input  logic [DIV_WIDTH-1:0] den_in,
    output logic [DIV_WIDTH:0]   rem_out,
    output logic [DIV_WIDTH-1:0] quot_out
);

    logic [DIV_WIDTH+1:0] shifted_rem;
    logic [DIV_WIDTH+1:0] trial_diff;

    // Shift in the next dividend bit and keep the trial difference when it
    // does not go negative. The shifted remainder is carried one bit wider
    // than R so the sign of the difference is always exact; R itself stays
    // below the divisor, so the kept difference fits back into R.
    always_comb begin
        shifted_rem = {rem_in, quot_in[DIV_WIDTH-1]};
        trial_diff  = shifted_rem - {2'b00, den_in};
        if (!trial_diff[DIV_WIDTH+1]) begin
            rem_out  = trial_diff[DIV_WIDTH:0];
            quot_out = {quot_in[DIV_WIDTH-2:0], 1'b1};
        end else begin
            rem_out  = shifted_rem[DIV_WIDTH:0];
            quot_out = {quot_in[DIV_WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/seqdiv32.sv
// Fixed-latency 32-bit signed/unsigned divider. Operands are latched on an
// accepted start, converted to magnitudes, run through 32 restoring
// iterations, sign-corrected, and presented with a one-cycle done pulse.
module seqdiv32
    import seqdiv32_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [DIV_WIDTH-1:0] dividend,
    input  logic [DIV_WIDTH-1:0] divisor,
    output logic                 ready,
    output logic                 done,
    output logic [DIV_WIDTH-1:0] quotient,
    output logic [DIV_WIDTH-1:0] remainder,
    output logic                 div_by_zero
);

    state_t               state_q, state_d;
    logic [4:0]           count_q, count_d;
    logic [DIV_WIDTH:0]   rem_work_q, rem_work_d;
    logic [DIV_WIDTH-1:0] num_q, num_d;
    logic [DIV_WIDTH-1:0] den_q, den_d;
    logic [DIV_WIDTH-1:0] orig_q, orig_d;
    logic                 signed_q, signed_d;
    logic                 neg_quot_q, neg_quot_d;
    logic                 neg_rem_q, neg_rem_d;
    logic [DIV_WIDTH-1:0] quotient_q, quotient_d;
    logic [DIV_WIDTH-1:0] remainder_q, remainder_d;
    logic                 dbz_q, dbz_d;

    logic [DIV_WIDTH:0]   step_rem;
    logic [DIV_WIDTH-1:0] step_quot;

    seqdiv32_div_step u_div_step (
        .rem_in   (rem_work_q),
        .quot_in  (num_q),
        .den_in   (den_q),
        .rem_out  (step_rem),
        .quot_out (step_quot)
    );

    // State register and all datapath flops; reset discards any divide in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            rem_work_q  <= '0;
            num_q       <= '0;
            den_q       <= '0;
            orig_q      <= '0;
            signed_q    <= 1'b0;
            neg_quot_q  <= 1'b0;
            neg_rem_q   <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rem_work_q  <= rem_work_d;
            num_q       <= num_d;
            den_q       <= den_d;
            orig_q      <= orig_d;
            signed_q    <= signed_d;
            neg_quot_q  <= neg_quot_d;
            neg_rem_q   <= neg_rem_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    // Next-state sequencing: one cycle each for PREP, FIX and DONE, 32 for ITER.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_PREP;
            ST_PREP: state_d = ST_ITER;
            ST_ITER: if (count_q == LAST_ITER) state_d = ST_FIX;
            ST_FIX:  state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded straight from the state.
    always_comb begin
        ready = (state_q == ST_IDLE);
        done  = (state_q == ST_DONE);
    end

    // Datapath: latch, take magnitudes, iterate, then sign-correct into the
    // result registers, which otherwise hold their value.
    always_comb begin
        count_d     = count_q;
        rem_work_d  = rem_work_q;
        num_d       = num_q;
        den_d       = den_q;
        orig_d      = orig_q;
        signed_d    = signed_q;
        neg_quot_d  = neg_quot_q;
        neg_rem_d   = neg_rem_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    num_d    = dividend;
                    den_d    = divisor;
                    orig_d   = dividend;
                    signed_d = is_signed;
                end
            end
            ST_PREP: begin
                neg_quot_d = signed_q & (num_q[DIV_WIDTH-1] ^ den_q[DIV_WIDTH-1]);
                neg_rem_d  = signed_q & num_q[DIV_WIDTH-1];
                if (signed_q) begin
                    num_d = magnitude32(num_q);
                    den_d = magnitude32(den_q);
                end
                rem_work_d = '0;
                count_d    = '0;
            end
            ST_ITER: begin
                rem_work_d = step_rem;
                num_d      = step_quot;
                count_d    = count_q + 5'd1;
            end
            ST_FIX: begin
                if (den_q == '0) begin
                    quotient_d  = DIV_ZERO_QUOTIENT;
                    remainder_d = orig_q;
                    dbz_d       = 1'b1;
                end else begin
                    quotient_d  = neg_quot_q ? (~num_q + 32'd1) : num_q;
                    remainder_d = neg_rem_q ? (~rem_work_q[DIV_WIDTH-1:0] + 32'd1)
                                            : rem_work_q[DIV_WIDTH-1:0];
                    dbz_d       = 1'b0;
                end
            end
            default: begin
            end
        endcase
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule
